// File: rtl/fb_pkg.sv
// Shared types for the framebuffer pattern engine: mode and FSM state encodings,
// default geometry and the per-mode pixel byte.
package fb_pkg;

    typedef enum logic [1:0] {
        MODE_WALK    = 2'd0,
        MODE_FILL    = 2'd1,
        MODE_CLEAR   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_ACK  = 2'd3
    } state_t;

    localparam int FB_WIDTH_DEF  = 128;
    localparam int FB_HEIGHT_DEF = 64;
    localparam int COORD_W_DEF   = 8;

    // Checkerboard only needs the coordinate LSBs: parity of x+y equals x^y bit 0.
    function automatic logic [7:0] pattern_byte(input mode_t m, input logic [7:0] fill,
                                                input logic x_lsb, input logic y_lsb);
        logic [7:0] b;
        b = 8'h00;
        case (m)
            MODE_WALK:    b = 8'hFF;
            MODE_FILL:    b = fill;
            MODE_CLEAR:   b = 8'h00;
            MODE_CHECKER: b = (x_lsb ^ y_lsb) ? 8'hFF : 8'h00;
            default:      b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fb_pattern_writer_if.sv
// Framebuffer write port as seen by the pattern writer (master) and the framebuffer (slave).
// Handshake: the master raises fb_we only when fb_busy and fb_w_data_valid are both low,
// holds fb_we, fb_w_xpos, fb_w_ypos and fb_din stable until the cycle fb_w_data_valid is
// high, then drops fb_we for at least one cycle before the next write.
interface fb_pattern_writer_if #(
    parameter int COORD_W = 8
);
    logic               fb_busy;
    logic               fb_w_data_valid;
    logic               fb_we;
    logic [COORD_W-1:0] fb_w_xpos;
    logic [COORD_W-1:0] fb_w_ypos;
    logic [7:0]         fb_din;

    modport master (
        input  fb_busy, fb_w_data_valid,
        output fb_we, fb_w_xpos, fb_w_ypos, fb_din
    );

    modport slave (
        output fb_busy, fb_w_data_valid,
        input  fb_we, fb_w_xpos, fb_w_ypos, fb_din
    );
endinterface

// File: rtl/step_timer.sv
// Loadable down-counter; expire is high during an enabled cycle once the count has hit zero.
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = en && (cnt_q == '0);
endmodule

// File: rtl/fb_pattern_writer.sv
// Pattern engine driving the monochrome framebuffer write port: timed walk, fill, clear
// and checkerboard, with start/stop control, a frame-done pulse and an ack watchdog.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int         FB_WIDTH    = FB_WIDTH_DEF,
    parameter int         FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int         COORD_W     = COORD_W_DEF,
    parameter int         STEP_CYCLES = 27000000,
    parameter logic [7:0] FILL_VALUE  = 8'hFF,
    parameter int         ACK_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    output logic                active,
    output logic                done,
    output logic                err,
    output state_t              dbg_state,
    fb_pattern_writer_if.master fb
);
    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam int WD_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(FB_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(FB_HEIGHT - 1);
    localparam logic [STEP_W-1:0]  STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [WD_W-1:0]    WD_LOAD   = WD_W'(ACK_TIMEOUT - 1);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [7:0]         din_q, din_d;
    logic               we_q, we_d;
    logic               stop_pend_q, stop_pend_d;
    logic               active_q, done_q, done_d, err_q, err_d;
    logic               step_load, step_exp, wd_load, wd_exp;
    logic               last_pos;
    logic [COORD_W-1:0] x_adv, y_adv;

    // Raster advance: x wraps into a y increment, y wraps back to the top row.
    assign last_pos = (x_q == X_LAST) && (y_q == Y_LAST);
    assign x_adv    = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    assign y_adv    = (x_q != X_LAST) ? y_q : ((y_q == Y_LAST) ? '0 : y_q + 1'b1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        din_d       = din_q;
        we_d        = we_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    mode_d  = mode_t'(mode);
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b0;
                    state_d = (mode_t'(mode) == MODE_WALK) ? ST_STEP_WAIT : ST_ISSUE;
                end
            end
            ST_STEP_WAIT: begin
                if (stop)          state_d = ST_IDLE;
                else if (step_exp) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!fb.fb_busy && !fb.fb_w_data_valid) begin
                    we_d    = 1'b1;
                    xpos_d  = x_q;
                    ypos_d  = y_q;
                    din_d   = pattern_byte(mode_q, FILL_VALUE, x_q[0], y_q[0]);
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (stop) stop_pend_d = 1'b1;
                // An ack arriving on the watchdog's final cycle still counts as success.
                if (fb.fb_w_data_valid) begin
                    we_d = 1'b0;
                    x_d  = x_adv;
                    y_d  = y_adv;
                    if (stop || stop_pend_q) begin
                        state_d = ST_IDLE;
                    end else if (mode_q == MODE_WALK) begin
                        state_d = ST_STEP_WAIT;
                    end else if (last_pos) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (wd_exp) begin
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign step_load = (state_d == ST_STEP_WAIT) && (state_q != ST_STEP_WAIT);
    assign wd_load   = (state_d == ST_WAIT_ACK) && (state_q != ST_WAIT_ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WALK;
            x_q         <= '0;
            y_q         <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            stop_pend_q <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            din_q       <= din_d;
            we_q        <= we_d;
            stop_pend_q <= stop_pend_d;
            active_q    <= (state_d != ST_IDLE);
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    step_timer #(.W(STEP_W)) u_step (
        .clk(clk), .rst(rst), .load(step_load), .load_val(STEP_LOAD),
        .en(state_q == ST_STEP_WAIT), .expire(step_exp)
    );

    step_timer #(.W(WD_W)) u_wdog (
        .clk(clk), .rst(rst), .load(wd_load), .load_val(WD_LOAD),
        .en(state_q == ST_WAIT_ACK), .expire(wd_exp)
    );

    assign active       = active_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_state    = state_q;
    assign fb.fb_we     = we_q;
    assign fb.fb_w_xpos = xpos_q;
    assign fb.fb_w_ypos = ypos_q;
    assign fb.fb_din    = din_q;
endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed and randomized bench for fb_pattern_writer on a 4x2 framebuffer, with a
// responsive framebuffer model and a raster-order reference of expected writes.
module tb_fb_pattern_writer;
    import fb_pkg::*;

    localparam int         FBW    = 4;
    localparam int         FBH    = 2;
    localparam int         STEP   = 5;
    localparam int         ACK_TO = 16;
    localparam logic [7:0] FILL_V = 8'h5A;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [1:0] mode;
    logic       active, done, err;
    state_t     dbg_state;

    fb_pattern_writer_if #(.COORD_W(8)) fb ();

    fb_pattern_writer #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COORD_W(8), .STEP_CYCLES(STEP),
        .FILL_VALUE(FILL_V), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .active(active), .done(done), .err(err), .dbg_state(dbg_state), .fb(fb)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] held;
    logic        prev_we;
    int          we_len, n_writes, done_cnt, hold, ack_delay;
    bit          ack_never, busy_rand, busy_force;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_din(input mode_t m, input int x, input int y);
        case (m)
            MODE_WALK:  return 8'hFF;
            MODE_FILL:  return FILL_V;
            MODE_CLEAR: return 8'h00;
            default:    return ((x + y) % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic push_frame(input mode_t m);
        for (int y = 0; y < FBH; y++)
            for (int x = 0; x < FBW; x++)
                exp_q.push_back({8'(x), 8'(y), model_din(m, x, y)});
    endtask

    // One clock: sample outputs 1 time unit after the edge, score writes, then drive the fb model.
    task automatic tick();
        logic [23:0] cur;
        @(posedge clk);
        #1;
        cur = {fb.fb_w_xpos, fb.fb_w_ypos, fb.fb_din};
        if (fb.fb_we && !prev_we) begin
            chk("issue_when_free", 32'({fb.fb_busy, fb.fb_w_data_valid}), 32'd0);
            n_writes++;
            we_len = 1;
            held   = cur;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("write_xy_din", 32'(cur), 32'(exp_q.pop_front()));
        end else if (fb.fb_we) begin
            we_len++;
            chk("write_hold", 32'(cur), 32'(held));
        end
        if (done) begin
            done_cnt++;
            chk("done_at_we_fall", 32'({prev_we, fb.fb_we}), 32'd2);
        end
        prev_we = fb.fb_we;
        if (fb.fb_w_data_valid) begin
            fb.fb_w_data_valid = 1'b0;
            hold = 0;
        end else if (fb.fb_we) begin
            hold++;
            if (!ack_never && hold >= ack_delay) fb.fb_w_data_valid = 1'b1;
        end else begin
            hold = 0;
            fb.fb_w_data_valid = busy_rand && ($urandom_range(0, 5) == 0);
        end
        fb.fb_busy = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
    endtask

    task automatic run_frame(input mode_t m, input bit with_stop);
        int w0, d0;
        w0 = n_writes;
        d0 = done_cnt;
        push_frame(m);
        mode  = m;
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        chk("start_active", 32'(active), 32'd1);
        chk("start_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 3000 && active; i++) begin
            start = (i == 4);
            tick();
            if (i == 0 && !busy_rand) chk("we_after_e1", 32'(fb.fb_we), 32'd1);
        end
        start = 1'b0;
        chk("frame_finished", 32'(active), 32'd0);
        chk("frame_writes", 32'(n_writes - w0), 32'(FBW * FBH));
        chk("frame_done_once", 32'(done_cnt - d0), 32'd1);
        chk("frame_exp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, w0, d0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
        fb.fb_busy = 1'b0; fb.fb_w_data_valid = 1'b0;
        prev_we = 1'b0; we_len = 0; n_writes = 0; done_cnt = 0; hold = 0;
        ack_delay = 1; ack_never = 1'b0; busy_rand = 1'b0; busy_force = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({active, done, err, fb.fb_we, fb.fb_w_xpos, fb.fb_w_ypos, fb.fb_din}), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        chk("idle_inactive", 32'(active), 32'd0);

        run_frame(MODE_FILL, 1'b0);
        run_frame(MODE_CHECKER, 1'b1);
        run_frame(MODE_CLEAR, 1'b0);

        busy_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            ack_delay = $urandom_range(1, 4);
            run_frame(mode_t'($urandom_range(1, 3)), 1'b0);
        end
        busy_rand = 1'b0;
        ack_delay = 1;

        // WALK: first write STEP+1 edges after start, raster wraps, never done.
        w0 = n_writes; d0 = done_cnt;
        push_frame(MODE_WALK);
        exp_q.push_back({8'd0, 8'd0, 8'hFF});
        mode = MODE_WALK; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!fb.fb_we && n < 50) begin
            tick();
            n++;
        end
        chk("walk_first_latency", 32'(n), 32'(STEP + 1));
        for (int i = 0; i < 1000 && !((n_writes - w0 == 9) && !fb.fb_we); i++) tick();
        chk("walk_writes", 32'(n_writes - w0), 32'd9);
        chk("walk_exp_drained", 32'(exp_q.size()), 32'd0);
        chk("walk_no_done", 32'(done_cnt - d0), 32'd0);
        chk("walk_step_wait", 32'(dbg_state), 32'(ST_STEP_WAIT));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("walk_stop_idle", 32'({active, fb.fb_we}), 32'd0);

        // Stop during a slow ack: write completes, then idle, no done.
        w0 = n_writes; d0 = done_cnt;
        ack_delay = 10;
        exp_q.push_back({8'd0, 8'd0, FILL_V});
        mode = MODE_FILL; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 40 && fb.fb_we; i++) tick();
        chk("stop_we_len", 32'(we_len), 32'd10);
        chk("stop_inactive", 32'(active), 32'd0);
        repeat (5) tick();
        chk("stop_one_write", 32'(n_writes - w0), 32'd1);
        chk("stop_no_done", 32'(done_cnt - d0), 32'd0);

        // Ack never arrives: watchdog drops fb_we and sets a sticky err.
        d0 = done_cnt;
        ack_never = 1'b1; ack_delay = 1;
        exp_q.push_back({8'd0, 8'd0, FILL_V});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 100 && fb.fb_we; i++) tick();
        chk("timeout_we_len", 32'(we_len), 32'(ACK_TO));
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_inactive", 32'(active), 32'd0);
        repeat (4) tick();
        chk("timeout_err_sticky", 32'(err), 32'd1);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        ack_never = 1'b0;

        // Restart clears err; reset mid-write with fb busy returns everything to zero.
        w0 = n_writes;
        push_frame(MODE_FILL);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 200 && !((n_writes - w0 == 3) && fb.fb_we); i++) tick();
        chk("midframe_writing", 32'(fb.fb_we), 32'd1);
        busy_force = 1'b1;
        fb.fb_busy = 1'b1;
        rst = 1'b1;
        tick();
        chk("midreset_outputs", 32'({active, done, err, fb.fb_we, fb.fb_w_xpos, fb.fb_w_ypos, fb.fb_din}), 32'd0);
        chk("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        chk("midreset_idle", 32'(active), 32'd0);
        exp_q.delete();
        busy_force = 1'b0;
        run_frame(MODE_FILL, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish before 500000");
        $fatal(1, "simulation time limit reached");
    end
endmodule
